prog_loader_ctrl: RTL and testbench
===================================

# prog_loader_ctrl

Boot sequencer for the single-cycle ARM core. It holds the core in reset and accepts program words over a valid/ready stream. Each word is written into instruction memory at consecutive word addresses from 0. Once the last word is committed, it releases the core to run, and it can later halt the core and return to idle for a reload. It sits between the external host/testbench and the instruction memory write port plus the core reset/run controls.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2^ADDR_W words
- DATA_W, 32, instruction word width

Ports (clock is `clk`, reset is `rst_n`):
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  request to begin a load; sampled only in IDLE
- load_len  in  ADDR_W+1  word count; sampled with load_start; legal range 1..2^ADDR_W
- halt_req  in  1  stop the core (in RUN) or abort a load (in LOAD)
- s_valid  in  1  program word available
- s_data  in  DATA_W  program word
- s_ready  out  1  controller accepts a word this cycle
- imem_we  out  1  instruction-memory write enable (registered)
- imem_addr  out  ADDR_W  word address (registered)
- imem_wdata  out  DATA_W  write data (registered)
- core_rst_n  out  1  core reset, active-low; low except in RUN
- core_run  out  1  high only in RUN
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse on the first RUN cycle
- err  out  1  sticky: illegal load_len seen; cleared by the next legal load_start

## Operation
- States: IDLE, LOAD, DRAIN, RUN.
- IDLE:
  - Outputs: s_ready=0, core_rst_n=0, core_run=0.
  - load_start with a legal load_len: latch the length, clear the word counter, clear err, go to LOAD.
  - load_start with load_len==0 or >2^ADDR_W: set err, stay in IDLE.
- LOAD:
  - s_ready=1 (decoded combinationally from state).
  - Beat = s_valid && s_ready. Each beat registers imem_we=1, imem_addr=cnt[ADDR_W-1:0], imem_wdata=s_data, then increments cnt.
  - The beat with cnt==len-1 moves to DRAIN.
  - load_start is ignored.
  - halt_req has priority over a same-cycle beat: that beat is not accepted (s_ready is forced low that cycle), go to IDLE, no done. Words already written stay in memory.
- DRAIN:
  - s_ready=0; the last write is in flight (imem_we=1).
  - Next cycle: RUN unconditionally. halt_req in DRAIN is ignored.
- RUN:
  - core_rst_n=1, core_run=1, imem_we=0.
  - halt_req: go to IDLE; core_rst_n goes low on the next edge.
  - load_start is ignored.
- imem_we is 0 in every cycle without a beat on the previous edge. imem_addr and imem_wdata hold their last value when not writing.
- cnt is ADDR_W+1 bits wide so a full-depth load (len=2^ADDR_W) terminates without wrap. Address bits use cnt[ADDR_W-1:0], so the last address is 2^ADDR_W-1.

## Timing
- Reset (async, any state, including mid-load): state=IDLE, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, core_run=0, busy=0, done=0, err=0, cnt=0, len=0. Any write in flight is dropped.
- load_start at edge k: state=LOAD and s_ready=1 from k+1.
- Beat at edge t: imem_we=1 with that word's address/data during cycle t..t+1; memory commits at edge t+1.
- Last beat at edge e: DRAIN during e..e+1. At edge e+1: RUN, core_rst_n=1, core_run=1, done=1 for exactly one cycle.
- A back-to-back stream (s_valid held high) of N words takes N cycles in LOAD plus 1 in DRAIN. It reaches RUN N+1 cycles after entering LOAD.
- Stalls: s_valid low in LOAD inserts idle cycles; no timeout.
- halt_req at edge h in RUN or LOAD: IDLE from h+1, core_rst_n=0 and core_run=0 from h+1.

## Structure
- Shared package `loader_pkg`: state enum typedef (IDLE, LOAD, DRAIN, RUN), default ADDR_W/DATA_W constants.
- Single module, no sub-module. The FSM, counter and write-port registers are tightly coupled.

## Test plan
- Reset mid-load, then load_len=3, words 0xE3A00001, 0xE2800002, 0xEAFFFFFE, continuous valid:
  - writes to addr 0,1,2 with those values on consecutive cycles;
  - done pulses once, 4 cycles after LOAD entry;
  - core_rst_n=1 from then on.
- load_len=4 with s_valid toggling 1,0,0,1,1,0,1: exactly 4 writes at addresses 0..3, s_ready drops the cycle after the 4th beat, no 5th beat accepted.
- Full-depth, ADDR_W=4, load_len=16: last write at addr 15, DRAIN then RUN, no address wrap to 0.
- load_len=0 and then load_len=17 (ADDR_W=4):
  - err=1, state stays IDLE, no imem_we;
  - a following legal load_start clears err.
- halt_req:
  - halt_req coincident with the 2nd beat of a 5-word load: beat not accepted, only addr 0 written, IDLE next cycle, no done;
  - halt_req in RUN: core_rst_n=0 next cycle, and a new load completes normally.
- Async reset asserted mid-cycle during DRAIN: all outputs take reset values immediately; done never pulses.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding and default bus widths.
package loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/prog_loader_ctrl.sv
// Boot sequencer: holds the core in reset, streams program words into imem from address 0, then releases the core.
// Write port is registered (one cycle after the beat); s_ready is high only in LOAD and is forced low by halt_req.
module prog_loader_ctrl
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              halt_req,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              core_run,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     r_len;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_done;
    logic                r_err;

    logic                w_len_ok;
    logic                w_start;
    logic                w_beat;
    logic                w_last;

    assign w_len_ok = (load_len != '0) && (load_len <= MAX_LEN);
    assign w_start  = (r_state == IDLE) && load_start;
    assign w_beat   = s_valid && s_ready;
    // Counter is one bit wider than the address so a full-depth load ends without wrapping.
    assign w_last   = (r_cnt == r_len - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (load_start && w_len_ok) w_state_nxt = LOAD;
            LOAD: begin
                if (halt_req)            w_state_nxt = IDLE;
                else if (w_beat && w_last) w_state_nxt = DRAIN;
            end
            DRAIN: w_state_nxt = RUN;
            RUN:   if (halt_req) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready    = (r_state == LOAD) && !halt_req;
        busy       = (r_state == LOAD) || (r_state == DRAIN);
        core_rst_n = (r_state == RUN);
        core_run   = (r_state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_len   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we   <= w_beat;
            r_done <= (r_state == DRAIN);
            if (w_start) begin
                r_err <= !w_len_ok;
                if (w_len_ok) begin
                    r_cnt <= '0;
                    r_len <= load_len;
                end
            end
            if (w_beat) begin
                r_addr  <= r_cnt[ADDR_W-1:0];
                r_wdata <= s_data;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Directed bench for prog_loader_ctrl at ADDR_W=4: vector table plus multi-cycle corner sequences.
module tb_prog_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [4:0]  load_len = '0;
    logic        halt_req = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, imem_we, core_rst_n, core_run, busy, done, err;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;

    int total = 0;
    int bad   = 0;

    logic [3:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic        done_seen = 1'b0;

    prog_loader_ctrl #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
        .halt_req(halt_req), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .core_run(core_run), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Memory-side view: a write commits on the edge after imem_we was registered.
    always @(posedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
        if (done) done_seen = 1'b1;
    end

    typedef struct {
        logic        ls;
        logic [4:0]  len;
        logic        halt;
        logic        v;
        logic [31:0] d;
        logic        e_rdy;
        logic        e_we;
        logic [3:0]  e_addr;
        logic [31:0] e_wd;
        logic        e_crst;
        logic        e_run;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic ls, input logic [4:0] len, input logic halt,
                                input logic v, input logic [31:0] d, input logic e_rdy,
                                input logic e_we, input logic [3:0] e_addr, input logic [31:0] e_wd,
                                input logic e_crst, input logic e_run, input logic e_busy,
                                input logic e_done, input logic e_err);
        vec_t r;
        r.ls = ls; r.len = len; r.halt = halt; r.v = v; r.d = d;
        r.e_rdy = e_rdy; r.e_we = e_we; r.e_addr = e_addr; r.e_wd = e_wd;
        r.e_crst = e_crst; r.e_run = e_run; r.e_busy = e_busy; r.e_done = e_done; r.e_err = e_err;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample s_ready before the edge, return #1 after the edge.
    task automatic cyc(input logic ls, input logic [4:0] len, input logic halt,
                       input logic v, input logic [31:0] d, output logic rdy_pre);
        @(negedge clk);
        load_start = ls; load_len = len; halt_req = halt; s_valid = v; s_data = d;
        #1 rdy_pre = s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"},  {31'b0, s_ready}, 32'd0);
        chk({tag, "_we"},   {31'b0, imem_we}, 32'd0);
        chk({tag, "_addr"}, {28'b0, imem_addr}, 32'd0);
        chk({tag, "_wd"},   imem_wdata, 32'd0);
        chk({tag, "_crst"}, {31'b0, core_rst_n}, 32'd0);
        chk({tag, "_run"},  {31'b0, core_run}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_err"},  {31'b0, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r;
        int   pat[7];
        int   zeros;

        // Reset-mid-load, then 3-word load and the IDLE-error cases.
        tbl[0]  = mk(1, 5'd3,  0, 0, 32'h0,        0, 0, 4'd0, 32'h0,        0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 5'd0,  0, 1, 32'hE3A00001, 1, 1, 4'd0, 32'hE3A00001, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 5'd0,  0, 1, 32'hE2800002, 1, 1, 4'd1, 32'hE2800002, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 5'd0,  0, 1, 32'hEAFFFFFE, 1, 1, 4'd2, 32'hEAFFFFFE, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 5'd0,  0, 1, 32'h12345678, 0, 0, 4'd2, 32'hEAFFFFFE, 1, 1, 0, 1, 0);
        tbl[5]  = mk(1, 5'd2,  0, 0, 32'h0,        0, 0, 4'd2, 32'hEAFFFFFE, 1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 5'd0,  1, 0, 32'h0,        0, 0, 4'd2, 32'hEAFFFFFE, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 5'd0,  0, 0, 32'h0,        0, 0, 4'd2, 32'hEAFFFFFE, 0, 0, 0, 0, 1);
        tbl[8]  = mk(1, 5'd17, 0, 1, 32'h0,        0, 0, 4'd2, 32'hEAFFFFFE, 0, 0, 0, 0, 1);
        tbl[9]  = mk(1, 5'd2,  0, 0, 32'h0,        0, 0, 4'd2, 32'hEAFFFFFE, 0, 0, 1, 0, 0);
        tbl[10] = mk(0, 5'd0,  1, 1, 32'hAAAA5555, 0, 0, 4'd2, 32'hEAFFFFFE, 0, 0, 0, 0, 0);

        #1 chk_reset_outputs("por");
        @(negedge clk); rst_n = 1'b1;

        cyc(1, 5'd5, 0, 0, 32'h0, r);
        cyc(0, 5'd0, 0, 1, 32'h11111111, r);
        cyc(0, 5'd0, 0, 1, 32'h22222222, r);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midload_rst");
        @(negedge clk); rst_n = 1'b1;
        wa_q.delete(); wd_q.delete();

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].ls, tbl[i].len, tbl[i].halt, tbl[i].v, tbl[i].d, r);
            chk($sformatf("v%0d_rdy", i),  {31'b0, r}, {31'b0, tbl[i].e_rdy});
            chk($sformatf("v%0d_we", i),   {31'b0, imem_we}, {31'b0, tbl[i].e_we});
            chk($sformatf("v%0d_addr", i), {28'b0, imem_addr}, {28'b0, tbl[i].e_addr});
            chk($sformatf("v%0d_wd", i),   imem_wdata, tbl[i].e_wd);
            chk($sformatf("v%0d_crst", i), {31'b0, core_rst_n}, {31'b0, tbl[i].e_crst});
            chk($sformatf("v%0d_run", i),  {31'b0, core_run}, {31'b0, tbl[i].e_run});
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
            chk($sformatf("v%0d_done", i), {31'b0, done}, {31'b0, tbl[i].e_done});
            chk($sformatf("v%0d_err", i),  {31'b0, err}, {31'b0, tbl[i].e_err});
        end
        chk("tbl_nwrites", wa_q.size(), 32'd3);

        // Stalled 4-word load: valid pattern 1,0,0,1,1,0,1.
        wa_q.delete(); wd_q.delete();
        pat = '{1, 0, 0, 1, 1, 0, 1};
        cyc(1, 5'd4, 0, 0, 32'h0, r);
        for (int i = 0; i < 7; i++) cyc(0, 5'd0, 0, pat[i][0], 32'hB0 + i, r);
        cyc(0, 5'd0, 0, 1, 32'hDEAD0000, r);
        chk("stall_rdy_after4", {31'b0, r}, 32'd0);
        chk("stall_done", {31'b0, done}, 32'd1);
        cyc(0, 5'd0, 0, 1, 32'hDEAD0001, r);
        chk("stall_nwrites", wa_q.size(), 32'd4);
        if (wa_q.size() == 4) begin
            chk("stall_a3", {28'b0, wa_q[3]}, 32'd3);
            chk("stall_d0", wd_q[0], 32'hB0);
            chk("stall_d1", wd_q[1], 32'hB3);
            chk("stall_d2", wd_q[2], 32'hB4);
            chk("stall_d3", wd_q[3], 32'hB6);
        end
        cyc(0, 5'd0, 1, 0, 32'h0, r);

        // Full-depth load of 16 words.
        wa_q.delete(); wd_q.delete();
        cyc(1, 5'd16, 0, 0, 32'h0, r);
        for (int i = 0; i < 16; i++) cyc(0, 5'd0, 0, 1, 32'hA0000000 + i, r);
        chk("full_drain_busy", {31'b0, busy}, 32'd1);
        chk("full_drain_addr", {28'b0, imem_addr}, 32'd15);
        cyc(0, 5'd0, 0, 1, 32'h0, r);
        chk("full_done", {31'b0, done}, 32'd1);
        chk("full_crst", {31'b0, core_rst_n}, 32'd1);
        chk("full_nwrites", wa_q.size(), 32'd16);
        zeros = 0;
        foreach (wa_q[i]) if (wa_q[i] == 4'd0) zeros++;
        chk("full_nowrap", zeros, 32'd1);
        if (wd_q.size() == 16) chk("full_last_d", wd_q[15], 32'hA000000F);

        // Halt in RUN, then a fresh 2-word load.
        cyc(0, 5'd0, 1, 0, 32'h0, r);
        chk("runhalt_crst", {31'b0, core_rst_n}, 32'd0);
        chk("runhalt_run", {31'b0, core_run}, 32'd0);
        cyc(1, 5'd2, 0, 1, 32'h0, r);
        cyc(0, 5'd0, 0, 1, 32'hC0, r);
        cyc(0, 5'd0, 0, 1, 32'hC1, r);
        cyc(0, 5'd0, 0, 0, 32'h0, r);
        chk("reload_done", {31'b0, done}, 32'd1);
        chk("reload_run", {31'b0, core_run}, 32'd1);
        cyc(0, 5'd0, 1, 0, 32'h0, r);

        // Halt coincident with the 2nd beat of a 5-word load.
        wa_q.delete(); wd_q.delete(); done_seen = 1'b0;
        cyc(1, 5'd5, 0, 0, 32'h0, r);
        cyc(0, 5'd0, 0, 1, 32'hD0, r);
        cyc(0, 5'd0, 1, 1, 32'hD1, r);
        chk("lhalt_rdy", {31'b0, r}, 32'd0);
        chk("lhalt_busy", {31'b0, busy}, 32'd0);
        cyc(0, 5'd0, 0, 1, 32'hD2, r);
        chk("lhalt_idle_rdy", {31'b0, r}, 32'd0);
        cyc(0, 5'd0, 0, 0, 32'h0, r);
        chk("lhalt_nwrites", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) chk("lhalt_a0", {wa_q[0], wd_q[0][27:0]}, {4'd0, 28'hD0});
        chk("lhalt_nodone", {31'b0, done_seen}, 32'd0);

        // Async reset in the middle of DRAIN: in-flight write dropped, no done.
        wa_q.delete(); wd_q.delete(); done_seen = 1'b0;
        cyc(1, 5'd1, 0, 0, 32'h0, r);
        cyc(0, 5'd0, 0, 1, 32'hE0, r);
        chk("drain_we", {31'b0, imem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("drain_rst");
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        cyc(0, 5'd0, 0, 0, 32'h0, r);
        cyc(0, 5'd0, 0, 0, 32'h0, r);
        chk("drain_nodone", {31'b0, done_seen}, 32'd0);
        chk("drain_nwrites", wa_q.size(), 32'd0);
        chk("drain_crst", {31'b0, core_rst_n}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
